// File: rtl/calc_core.sv
// ---------------------------------------------------------------------------
// calc_core -- sign-magnitude BCD calculator core.
//
// Handles keypad strobes (digits, ADD, SUB, EQ, CLEAR). It holds the display
// register D, the upper operand U, the pending operation and the class of
// the last accepted key. An internal handshaked BCD ALU performs the
// add/subtract for EQ.
//
// Number format: bit W-1 is the sign (1 = negative). The magnitude is
// NUM_DIGITS BCD digits with the least significant digit in bits [3:0].
// Zero is always positive.
//
// Optional feature macro: CALC_SATURATE_EN
//   defined   : an overflowing result becomes all nines, keeping the exact sign
//   undefined : an overflowing result wraps modulo 10^NUM_DIGITS
//
// Ports:
//   clk_i        in   1  clock, rising edge
//   rst_ni       in   1  asynchronous active-low reset
//   button_i     in   5  key code (0x01..0x0A digits 0..9, 0x10 ADD,
//                        0x11 SUB, 0x12 EQ, 0x13 CLEAR)
//   new_input_i  in   1  one-cycle strobe, button_i valid
//   busy_o       out  1  an EQ operation is in flight
//   display_o    out  W  display register D
//   upper_o      out  W  upper operand register U
//   alu_result_o out  W  last ALU result, held
// ---------------------------------------------------------------------------
module calc_core #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int ALU_LATENCY = 2,
  localparam int W           = 1 + 4*NUM_DIGITS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [4:0]   button_i,
  input  logic         new_input_i,
  output logic         busy_o,
  output logic [W-1:0] display_o,
  output logic [W-1:0] upper_o,
  output logic [W-1:0] alu_result_o
);

  localparam int MW = 4*NUM_DIGITS;
  localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [MW-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};
`ifdef CALC_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_EQ  = 5'h12;
  localparam logic [4:0] KEY_CLR = 5'h13;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_WRITE} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB} op_e;
  typedef enum logic [1:0] {K_NONE, K_DIGIT, K_OP, K_EQ} key_e;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  key_e           last_q, last_d;
  logic [W-1:0]   disp_q, disp_d;
  logic [W-1:0]   upper_q, upper_d;
  logic [W-1:0]   result_q, result_d;
  logic           alu_busy_q, alu_busy_d;
  logic [CW-1:0]  alu_cnt_q, alu_cnt_d;
  logic [W-1:0]   alu_res_q, alu_res_d;

  // ---- BCD magnitude helpers ---------------------------------------------
  // Ripple digit-wise add; the extra MSB is the decimal carry out.
  function automatic logic [MW:0] bcd_add(input logic [MW-1:0] a,
                                          input logic [MW-1:0] b);
    logic [MW-1:0] r;
    logic [4:0]    s;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      s = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'b0, c};
      c = (s > 5'd9);
      if (c) s = s + 5'd6;
      r[4*k +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // Digit-wise subtract; caller guarantees a >= b, so no final borrow.
  function automatic logic [MW-1:0] bcd_sub(input logic [MW-1:0] a,
                                            input logic [MW-1:0] b);
    logic [MW-1:0] r;
    logic [4:0]    s;
    logic          bw;
    r  = '0;
    bw = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      s  = {1'b0, a[4*k +: 4]} - {1'b0, b[4*k +: 4]} - {4'b0, bw};
      bw = s[4];
      if (bw) s = s + 5'd10;
      r[4*k +: 4] = s[3:0];
    end
    return r;
  endfunction

  // ---- ALU datapath --------------------------------------------------------
  // A repeated EQ reuses the previous right operand: D op U instead of U op D.
  logic [W-1:0]  alu_a, alu_b, alu_val;
  logic [MW:0]   sum;
  logic [MW-1:0] mag;
  logic          sign, ovf, sb;
  logic          alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready;

  assign alu_a = (last_q == K_EQ) ? disp_q  : upper_q;
  assign alu_b = (last_q == K_EQ) ? upper_q : disp_q;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum  = '0;
    mag  = '0;
    sign = 1'b0;
    ovf  = 1'b0;
    // Subtraction is addition with the right operand's sign flipped.
    sb   = alu_b[W-1] ^ (op_q == OP_SUB);
    if (alu_a[W-1] == sb) begin
      sum  = bcd_add(alu_a[MW-1:0], alu_b[MW-1:0]);
      ovf  = sum[MW];
      mag  = sum[MW-1:0];
      sign = sb;
    end else if (alu_a[MW-1:0] >= alu_b[MW-1:0]) begin
      // BCD digits compare correctly as plain unsigned binary.
      mag  = bcd_sub(alu_a[MW-1:0], alu_b[MW-1:0]);
      sign = alu_a[W-1];
    end else begin
      mag  = bcd_sub(alu_b[MW-1:0], alu_a[MW-1:0]);
      sign = sb;
    end
    if (ovf && SATURATE) mag = ALL_NINES;
    if (mag == '0) sign = 1'b0;
    alu_val = {sign, mag};
  end

  // ---- ALU handshake: accept, hold ALU_LATENCY cycles, then offer ---------
  assign alu_in_valid  = (state_q == ST_REQ);
  assign alu_out_ready = (state_q == ST_WAIT);
  assign alu_in_ready  = !alu_busy_q;
  assign alu_out_valid = alu_busy_q && (alu_cnt_q == '0);

  always_comb begin
    alu_busy_d = alu_busy_q;
    alu_cnt_d  = alu_cnt_q;
    alu_res_d  = alu_res_q;
    if (!alu_busy_q) begin
      if (alu_in_valid) begin
        alu_busy_d = 1'b1;
        alu_cnt_d  = CW'(ALU_LATENCY - 1);
        alu_res_d  = alu_val;
      end
    end else if (alu_cnt_q != '0) begin
      alu_cnt_d = alu_cnt_q - 1'b1;
    end else if (alu_out_ready) begin
      alu_busy_d = 1'b0;
    end
  end

  // ---- Key handling and control FSM --------------------------------------
  logic       is_digit;
  logic [3:0] digit;

  assign is_digit = (button_i >= 5'h01) && (button_i <= 5'h0A);
  assign digit    = 4'(button_i - 5'd1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    last_d   = last_q;
    disp_d   = disp_q;
    upper_d  = upper_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (new_input_i) begin
          if (is_digit) begin
            unique case (last_q)
              K_OP: begin
                upper_d = disp_q;
                disp_d  = {{(W-4){1'b0}}, digit};
                last_d  = K_DIGIT;
              end
              K_EQ: begin
                disp_d = {{(W-4){1'b0}}, digit};
                last_d = K_DIGIT;
              end
              default: begin
                // A full display (nonzero top digit) ignores further digits.
                if (disp_q[MW-1 -: 4] == 4'h0) begin
                  disp_d = {disp_q[W-1], disp_q[MW-5:0], digit};
                  last_d = K_DIGIT;
                end
              end
            endcase
          end else if (button_i == KEY_ADD) begin
            op_d   = OP_ADD;
            last_d = K_OP;
          end else if (button_i == KEY_SUB) begin
            op_d   = OP_SUB;
            last_d = K_OP;
          end else if (button_i == KEY_CLR) begin
            disp_d  = '0;
            upper_d = '0;
            op_d    = OP_NONE;
            last_d  = K_NONE;
          end else if (button_i == KEY_EQ && op_q != OP_NONE) begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ:   if (alu_in_ready)  state_d = ST_WAIT;
      ST_WAIT:  if (alu_out_valid) state_d = ST_WRITE;
      ST_WRITE: begin
        disp_d   = alu_res_q;
        result_d = alu_res_q;
        if (last_q != K_EQ) upper_d = disp_q;
        last_d   = K_EQ;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      last_q     <= K_NONE;
      disp_q     <= '0;
      upper_q    <= '0;
      result_q   <= '0;
      alu_busy_q <= 1'b0;
      alu_cnt_q  <= '0;
      alu_res_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      last_q     <= last_d;
      disp_q     <= disp_d;
      upper_q    <= upper_d;
      result_q   <= result_d;
      alu_busy_q <= alu_busy_d;
      alu_cnt_q  <= alu_cnt_d;
      alu_res_q  <= alu_res_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign display_o    = disp_q;
  assign upper_o      = upper_q;
  assign alu_result_o = result_q;

endmodule

// File: tb/tb_calc_core.sv
// ---------------------------------------------------------------------------
// tb_calc_core -- directed bench for calc_core (NUM_DIGITS=8, ALU_LATENCY=2).
// Each key press is strobed for one cycle on the falling edge. The bench then
// waits, with a bounded loop, for busy to drop and compares D/U/result
// against hand-computed values on the falling edge.
// ---------------------------------------------------------------------------
module tb_calc_core;

  localparam int ND  = 8;
  localparam int LAT = 2;
  localparam int W   = 1 + 4*ND;

  localparam logic [4:0] ADD = 5'h10;
  localparam logic [4:0] SUB = 5'h11;
  localparam logic [4:0] EQ  = 5'h12;
  localparam logic [4:0] CLR = 5'h13;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   button = 5'h00;
  logic         new_input = 1'b0;
  logic         busy;
  logic [W-1:0] display, upper, alu_result;

  int n_tests = 0;
  int n_fail  = 0;
  int last_busy = 0;

  calc_core #(.NUM_DIGITS(ND), .ALU_LATENCY(LAT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .button_i     (button),
    .new_input_i  (new_input),
    .busy_o       (busy),
    .display_o    (display),
    .upper_o      (upper),
    .alu_result_o (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pos(input logic [4*ND-1:0] m);
    return {1'b0, m};
  endfunction

  function automatic logic [W-1:0] neg(input logic [4*ND-1:0] m);
    return {1'b1, m};
  endfunction

  function automatic logic [4:0] dk(input int d);
    return 5'(d + 1);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe one key, then wait (bounded) until the core is idle again.
  task automatic key(input logic [4:0] code);
    @(negedge clk);
    button    = code;
    new_input = 1'b1;
    @(negedge clk);
    new_input = 1'b0;
    button    = 5'h00;
    last_busy = 0;
    while (busy && last_busy < 50) begin
      last_busy++;
      @(negedge clk);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] code,
                      input logic [W-1:0] exp_d, input logic [W-1:0] exp_u);
    key(code);
    check({tag, "_d"}, display, exp_d);
    check({tag, "_u"}, upper, exp_u);
  endtask

  // Fibonacci-style chain: 1, ADD, 1, EQ, (ADD, EQ) x3, ADD
  logic [4:0]  fib_code [11] = '{5'h02, ADD, 5'h02, EQ, ADD, EQ, ADD, EQ, ADD, EQ, ADD};
  logic [31:0] fib_d    [11] = '{1, 1, 1, 2, 2, 3, 3, 5, 5, 8, 8};
  logic [31:0] fib_u    [11] = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 5, 5};

  // ADD, 3, EQ, 1, ADD, EQ x5
  logic [4:0]  chn_code [10] = '{ADD, 5'h04, EQ, 5'h02, ADD, EQ, EQ, EQ, EQ, EQ};
  logic [31:0] chn_d    [10] = '{0, 3, 3, 1, 1, 4, 5, 6, 7, 8};
  logic [31:0] chn_u    [10] = '{0, 0, 3, 3, 3, 1, 1, 1, 1, 1};

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_d", display, pos(0));
    check("rst_u", upper, pos(0));
    check("rst_res", alu_result, pos(0));
    check("rst_busy", W'(busy), W'(0));
    rst_n = 1'b1;

    // ---- 1, ADD, EQ x5 ----
    step("a1", dk(1), pos(1), pos(0));
    step("a2", ADD, pos(1), pos(0));
    step("a3", EQ, pos(1), pos(1));
    check("a3_busy", W'(last_busy), W'(LAT + 2));
    step("a4", EQ, pos(2), pos(1));
    step("a5", EQ, pos(3), pos(1));
    step("a6", EQ, pos(4), pos(1));
    step("a7", EQ, pos(5), pos(1));
    check("a7_res", alu_result, pos(5));
    step("clr1", CLR, pos(0), pos(0));
    check("clr1_res_held", alu_result, pos(5));

    // ---- EQ with no pending op does nothing ----
    step("b1", dk(3), pos(3), pos(0));
    step("b2", EQ, pos(3), pos(0));
    check("b2_busy", W'(last_busy), W'(0));
    step("clr2", CLR, pos(0), pos(0));

    // ---- ADD, 3, EQ, 1, ADD, EQ x5 ----
    for (int i = 0; i < 10; i++)
      step($sformatf("c%0d", i), chn_code[i], pos(chn_d[i]), pos(chn_u[i]));
    step("clr3", CLR, pos(0), pos(0));

    // ---- Fibonacci chain, then 1, EQ x5 after CLEAR ----
    for (int i = 0; i < 11; i++)
      step($sformatf("f%0d", i), fib_code[i], pos(fib_d[i]), pos(fib_u[i]));
    step("clr4", CLR, pos(0), pos(0));
    step("g0", dk(1), pos(1), pos(0));
    for (int i = 0; i < 5; i++) begin
      key(EQ);
      check($sformatf("g%0d_d", i + 1), display, pos(1));
      check($sformatf("g%0d_busy", i + 1), W'(last_busy), W'(0));
    end
    step("clr5", CLR, pos(0), pos(0));

    // ---- negative results and sign handling ----
    step("s1", dk(3), pos(3), pos(0));
    step("s2", SUB, pos(3), pos(0));
    step("s3", dk(5), pos(5), pos(3));
    step("s4", EQ, neg(2), pos(5));            // 3 - 5
    check("s4_busy", W'(last_busy), W'(LAT + 2));
    check("s4_res", alu_result, neg(2));
    step("s5", EQ, neg(7), pos(5));            // repeat: -2 - 5
    step("s6", ADD, neg(7), pos(5));
    step("s7", dk(9), pos(9), neg(7));
    step("s8", EQ, pos(2), pos(9));            // -7 + 9
    step("clr6", CLR, pos(0), pos(0));
    step("z1", dk(2), pos(2), pos(0));
    step("z2", SUB, pos(2), pos(0));
    step("z3", dk(7), pos(7), pos(2));
    step("z4", EQ, neg(5), pos(7));            // 2 - 7
    step("z5", ADD, neg(5), pos(7));
    step("z6", dk(5), pos(5), neg(5));
    step("z7", EQ, pos(0), pos(5));            // -5 + 5 is +0

    // ---- NONE and invalid codes are ignored ----
    step("inv1", 5'h0B, pos(0), pos(5));
    step("inv2", 5'h14, pos(0), pos(5));
    step("inv3", 5'h00, pos(0), pos(5));
    step("inv4", dk(6), pos(6), pos(5));       // after EQ a digit replaces D

    // ---- strobe while busy is ignored ----
    step("clr7", CLR, pos(0), pos(0));
    step("w1", dk(9), pos(9), pos(0));
    step("w2", SUB, pos(9), pos(0));
    step("w3", dk(2), pos(2), pos(9));
    @(negedge clk);
    button = EQ;     new_input = 1'b1;
    @(negedge clk);
    button = dk(4);  new_input = 1'b1;         // busy now, must be dropped
    @(negedge clk);
    button = 5'h00;  new_input = 1'b0;
    last_busy = 0;
    while (busy && last_busy < 50) begin
      last_busy++;
      @(negedge clk);
    end
    check("w4_d", display, pos(7));            // 9 - 2
    check("w4_u", upper, pos(2));
    check("w4_res", alu_result, pos(7));

    // ---- async reset in the middle of an operation ----
    step("r1", dk(2), pos(2), pos(2));
    step("r2", ADD, pos(2), pos(2));
    step("r3", dk(3), pos(3), pos(2));
    @(negedge clk);
    button = EQ;  new_input = 1'b1;
    @(negedge clk);
    button = 5'h00;  new_input = 1'b0;
    check("r4_busy", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("r5_busy", W'(busy), W'(0));
    check("r5_d", display, pos(0));
    check("r5_u", upper, pos(0));
    check("r5_res", alu_result, pos(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step("r6", EQ, pos(0), pos(0));            // pending op was cleared
    check("r6_busy", W'(last_busy), W'(0));

    // ---- full display and overflow ----
    for (int i = 0; i < 8; i++) key(dk(9));
    check("o1_d", display, pos(32'h99999999));
    step("o2", dk(9), pos(32'h99999999), pos(0));   // 9th digit ignored
    step("o3", ADD, pos(32'h99999999), pos(0));
    step("o4", dk(1), pos(1), pos(32'h99999999));
`ifdef CALC_SATURATE_EN
    step("o5", EQ, pos(32'h99999999), pos(1));
`else
    step("o5", EQ, pos(0), pos(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
